// File: rtl/obstacle_pkg.sv
// Shared constants, default palette, tile ROM contents and the position fold-hash
// for the obstacle tile renderer.
package obstacle_pkg;

    localparam int STYLE_NUM_DEF   = 4;
    localparam int ANIM_FRAMES_DEF = 2;
    localparam int COLOR_NUM_DEF   = 4;

    localparam int STYLE_W   = $clog2(STYLE_NUM_DEF);
    localparam int PHASE_W   = $clog2(ANIM_FRAMES_DEF);
    localparam int CID_W     = $clog2(COLOR_NUM_DEF);
    localparam int LX_W      = 4;
    localparam int LY_W      = 4;
    localparam int ROM_AW    = STYLE_W + PHASE_W + LY_W + LX_W;
    localparam int ROM_DEPTH = 1 << ROM_AW;

    localparam logic [11:0] PAL_DEF_0 = 12'hAAA;
    localparam logic [11:0] PAL_DEF_1 = 12'h777;
    localparam logic [11:0] PAL_DEF_2 = 12'h000;
    localparam logic [11:0] PAL_DEF_3 = 12'h5B0;

    localparam string ROM_INIT_FILE = "obstacle_tiles.mem";

    function automatic logic [11:0] pal_default(input int unsigned idx);
        case (idx)
            0:       return PAL_DEF_0;
            1:       return PAL_DEF_1;
            2:       return PAL_DEF_2;
            3:       return PAL_DEF_3;
            default: return 12'h000;
        endcase
    endfunction

    // XOR of all hw-wide slices of v; bits above the top slice read as zero.
    function automatic logic [31:0] fold_hash(input logic [31:0] v, input int unsigned hw,
                                              input int unsigned n);
        logic [31:0] h;
        logic [31:0] mask;
        h    = '0;
        mask = (32'd1 << hw) - 32'd1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n) h = h ^ ((v >> (i * hw)) & mask);
        end
        return h;
    endfunction

    // Tile artwork: colour id per ROM address (matches ROM_INIT_FILE).
    function automatic logic [7:0] rom_word(input logic [31:0] a);
        logic [31:0] t;
        t = a + (a >> 2) + (a >> 4) + (a >> 6) + (a >> 8);
        return t[7:0];
    endfunction

endpackage

// File: rtl/obstacle_style_rom.sv
// Tile colour-id ROM: synchronous single-port read.
// Latency 1 cycle; no backpressure, reads every cycle.
// Always ready; output register holds the last addressed word.
module obstacle_style_rom
    import obstacle_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int DW = CID_W
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    (* rom_style = "block" *) logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    always_comb begin
        data_d = DW'(rom_word(32'(addr)));
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/obstacle_tile_renderer.sv
// Obstacle wall tile renderer: hash-selected style, mirror, animation, palette lookup.
// Latency 3 cycles, 1 pixel/cycle.
// No backpressure; bubbles propagate as rgb_valid=0.
module obstacle_tile_renderer
    import obstacle_pkg::*;
#(
    parameter int SCREEN_WIDTH              = 10,
    parameter int PHY_WIDTH                 = 14,
    parameter int PIXEL_WIDTH               = 12,
    parameter int TILE_W                    = 10,
    parameter int TILE_H_SHIFT              = 1,
    parameter int STYLE_NUM                 = STYLE_NUM_DEF,
    parameter int ANIM_FRAMES               = ANIM_FRAMES_DEF,
    parameter int ANIM_DIV                  = 30,
    parameter logic [STYLE_NUM-1:0] ANIM_MASK = 4'b1010,
    parameter int COLOR_NUM                 = COLOR_NUM_DEF,
    parameter int HASH_W                    = 3
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          pix_valid_in,
    input  logic [SCREEN_WIDTH-1:0]       obstacle_x_rom,
    input  logic [SCREEN_WIDTH-1:0]       obstacle_y_rom,
    input  logic [PHY_WIDTH-1:0]          obstacle_abs_pos_x,
    input  logic [PHY_WIDTH-1:0]          obstacle_abs_pos_y,
    input  logic                          obstacle_on,
    input  logic                          frame_start,
    input  logic                          pal_we,
    input  logic [$clog2(COLOR_NUM)-1:0]  pal_addr,
    input  logic [PIXEL_WIDTH-1:0]        pal_data,
    output logic [PIXEL_WIDTH-1:0]        rgb,
    output logic                          rgb_on,
    output logic                          rgb_valid
);

    localparam int STYLE_BITS = $clog2(STYLE_NUM);
    localparam int PH_BITS    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int CID_BITS   = $clog2(COLOR_NUM);
    localparam int LX_BITS    = $clog2(TILE_W);
    localparam int AW         = STYLE_BITS + PH_BITS + LY_W + LX_BITS;
    localparam int FC_BITS    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int NSLICE     = (PHY_WIDTH + HASH_W - 1) / HASH_W;

    logic [HASH_W-1:0]       hash;
    logic [STYLE_BITS-1:0]   style;
    logic                    mirror;
    logic [SCREEN_WIDTH-1:0] x_mod;
    logic [LX_BITS-1:0]      lx;
    logic [LY_W-1:0]         ly;

    logic                    s1_vld_q, s1_vld_d, s1_on_q, s1_on_d;
    logic [STYLE_BITS-1:0]   s1_style_q, s1_style_d;
    logic [PH_BITS-1:0]      s1_phase_q, s1_phase_d;
    logic [LX_BITS-1:0]      s1_lx_q, s1_lx_d;
    logic [LY_W-1:0]         s1_ly_q, s1_ly_d;
    logic                    s2_vld_q, s2_vld_d, s2_on_q, s2_on_d;
    logic [CID_BITS-1:0]     s2_cid;
    logic [AW-1:0]           rom_addr;
    logic [PIXEL_WIDTH-1:0]  rgb_q, rgb_d;
    logic                    rgb_on_q, rgb_on_d, rgb_vld_q, rgb_vld_d;
    logic [FC_BITS-1:0]      frame_cnt_q, frame_cnt_d;
    logic [PH_BITS-1:0]      anim_phase_q, anim_phase_d;
    logic [PIXEL_WIDTH-1:0]  pal_q [COLOR_NUM];
    logic [PIXEL_WIDTH-1:0]  pal_d [COLOR_NUM];

    logic unused_bits;
    assign unused_bits = ^{obstacle_abs_pos_x, hash};

    always_comb begin
        hash   = HASH_W'(fold_hash(32'(obstacle_abs_pos_y), HASH_W, NSLICE));
        style  = hash[STYLE_BITS-1:0];
        mirror = hash[1] ^ hash[0];
        x_mod  = obstacle_x_rom % SCREEN_WIDTH'(TILE_W);
        lx     = mirror ? (LX_BITS'(TILE_W - 1) - LX_BITS'(x_mod)) : LX_BITS'(x_mod);
        ly     = LY_W'(obstacle_y_rom >> TILE_H_SHIFT);
    end

    always_comb begin
        s1_vld_d   = pix_valid_in;
        s1_on_d    = obstacle_on;
        s1_style_d = style;
        // Phase sampled before any same-cycle frame_start update takes effect.
        s1_phase_d = ANIM_MASK[style] ? anim_phase_q : '0;
        s1_lx_d    = lx;
        s1_ly_d    = ly;

        s2_vld_d   = s1_vld_q;
        s2_on_d    = s1_on_q;

        rgb_vld_d  = s2_vld_q;
        rgb_on_d   = s2_vld_q & s2_on_q;
        rgb_d      = rgb_on_d ? pal_q[s2_cid] : '0;

        frame_cnt_d  = frame_cnt_q;
        anim_phase_d = anim_phase_q;
        if (frame_start) begin
            if (frame_cnt_q == FC_BITS'(ANIM_DIV - 1)) begin
                frame_cnt_d  = '0;
                anim_phase_d = (ANIM_FRAMES > 1) ? anim_phase_q + PH_BITS'(1) : '0;
            end else begin
                frame_cnt_d  = frame_cnt_q + FC_BITS'(1);
            end
        end

        pal_d = pal_q;
        if (pal_we) pal_d[pal_addr] = pal_data;
    end

    assign rom_addr = {s1_style_q, s1_phase_q, s1_ly_q, s1_lx_q};

    obstacle_style_rom #(
        .AW (AW),
        .DW (CID_BITS)
    ) u_rom (
        .clk  (sys_clk),
        .addr (rom_addr),
        .data (s2_cid)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_vld_q     <= 1'b0;
            s1_on_q      <= 1'b0;
            s1_style_q   <= '0;
            s1_phase_q   <= '0;
            s1_lx_q      <= '0;
            s1_ly_q      <= '0;
            s2_vld_q     <= 1'b0;
            s2_on_q      <= 1'b0;
            rgb_q        <= '0;
            rgb_on_q     <= 1'b0;
            rgb_vld_q    <= 1'b0;
            frame_cnt_q  <= '0;
            anim_phase_q <= '0;
            for (int i = 0; i < COLOR_NUM; i++) begin
                pal_q[i] <= PIXEL_WIDTH'(pal_default(i));
            end
        end else begin
            s1_vld_q     <= s1_vld_d;
            s1_on_q      <= s1_on_d;
            s1_style_q   <= s1_style_d;
            s1_phase_q   <= s1_phase_d;
            s1_lx_q      <= s1_lx_d;
            s1_ly_q      <= s1_ly_d;
            s2_vld_q     <= s2_vld_d;
            s2_on_q      <= s2_on_d;
            rgb_q        <= rgb_d;
            rgb_on_q     <= rgb_on_d;
            rgb_vld_q    <= rgb_vld_d;
            frame_cnt_q  <= frame_cnt_d;
            anim_phase_q <= anim_phase_d;
            pal_q        <= pal_d;
        end
    end

    assign rgb       = rgb_q;
    assign rgb_on    = rgb_on_q;
    assign rgb_valid = rgb_vld_q;

endmodule

// File: tb/tb_obstacle_tile_renderer.sv
// Directed + randomized bench for obstacle_tile_renderer against a transaction-level
// model: hash/mirror/phase/palette computed with plain integer arithmetic.
module tb_obstacle_tile_renderer;

    logic        sys_clk;
    logic        sys_rst;
    logic        pix_valid_in;
    logic [9:0]  obstacle_x_rom;
    logic [9:0]  obstacle_y_rom;
    logic [13:0] obstacle_abs_pos_x;
    logic [13:0] obstacle_abs_pos_y;
    logic        obstacle_on;
    logic        frame_start;
    logic        pal_we;
    logic [1:0]  pal_addr;
    logic [11:0] pal_data;
    logic [11:0] rgb;
    logic        rgb_on;
    logic        rgb_valid;

    int    checks = 0;
    int    errors = 0;
    string cur_tag = "";

    int m_pal [4];
    int m_phase;
    int m_fcnt;
    int pend_vld [2];
    int pend_on  [2];
    int pend_cid [2];

    obstacle_tile_renderer dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .pix_valid_in       (pix_valid_in),
        .obstacle_x_rom     (obstacle_x_rom),
        .obstacle_y_rom     (obstacle_y_rom),
        .obstacle_abs_pos_x (obstacle_abs_pos_x),
        .obstacle_abs_pos_y (obstacle_abs_pos_y),
        .obstacle_on        (obstacle_on),
        .frame_start        (frame_start),
        .pal_we             (pal_we),
        .pal_addr           (pal_addr),
        .pal_data           (pal_data),
        .rgb                (rgb),
        .rgb_on             (rgb_on),
        .rgb_valid          (rgb_valid)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Tile artwork as published with the design: colour id = (sum of a>>2k, k=0..4) mod 4.
    function automatic int m_rom(input int a);
        int t;
        t = a + (a / 4) + (a / 16) + (a / 64) + (a / 256);
        return t % 4;
    endfunction

    function automatic int m_hash(input int py);
        int h;
        int v;
        h = 0;
        v = py;
        while (v != 0) begin
            h = h ^ (v % 8);
            v = v / 8;
        end
        return h;
    endfunction

    function automatic int m_cid(input int x, input int y, input int py);
        int h, style, mirror, lx, ly, ph;
        h      = m_hash(py);
        style  = h % 4;
        mirror = ((h / 2) ^ h) % 2;
        lx     = x % 10;
        if (mirror != 0) lx = 9 - lx;
        ly     = (y / 2) % 16;
        ph     = (style == 1 || style == 3) ? m_phase : 0;
        return m_rom(((style * 2 + ph) * 16 + ly) * 16 + lx);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int x, input int y, input int py, input int on);
        pix_valid_in       = 1'b1;
        obstacle_x_rom     = 10'(x);
        obstacle_y_rom     = 10'(y);
        obstacle_abs_pos_y = 14'(py);
        obstacle_abs_pos_x = 14'($urandom);
        obstacle_on        = 1'(on);
    endtask

    // One clock: apply current inputs, advance the model, compare outputs.
    task automatic tick();
        int e_vld, e_on, e_rgb;
        @(posedge sys_clk);
        #1;
        if (sys_rst) begin
            pend_vld = '{0, 0};
            pend_on  = '{0, 0};
            pend_cid = '{0, 0};
            m_pal    = '{32'hAAA, 32'h777, 32'h000, 32'h5B0};
            m_phase  = 0;
            m_fcnt   = 0;
            check({cur_tag, ":rst_vld"}, 32'(rgb_valid), 0);
            check({cur_tag, ":rst_rgb"}, 32'(rgb), 0);
            check({cur_tag, ":rst_on"},  32'(rgb_on), 0);
        end else begin
            e_vld = pend_vld[1];
            e_on  = pend_on[1];
            e_rgb = (e_on != 0) ? m_pal[pend_cid[1]] : 0;
            pend_vld[1] = pend_vld[0];
            pend_on[1]  = pend_on[0];
            pend_cid[1] = pend_cid[0];
            pend_vld[0] = int'(pix_valid_in);
            pend_on[0]  = int'(obstacle_on);
            pend_cid[0] = m_cid(int'(obstacle_x_rom), int'(obstacle_y_rom),
                                int'(obstacle_abs_pos_y));
            if (pal_we) m_pal[pal_addr] = int'(pal_data);
            if (frame_start) begin
                if (m_fcnt == 29) begin
                    m_fcnt  = 0;
                    m_phase = (m_phase + 1) % 2;
                end else begin
                    m_fcnt = m_fcnt + 1;
                end
            end
            check({cur_tag, ":vld"}, 32'(rgb_valid), 32'(e_vld));
            if (e_vld != 0) begin
                check({cur_tag, ":rgb"}, 32'(rgb), 32'(e_rgb));
                check({cur_tag, ":on"},  32'(rgb_on), 32'(e_on));
            end
        end
        pix_valid_in = 1'b0;
        frame_start  = 1'b0;
        pal_we       = 1'b0;
        sys_rst      = 1'b0;
    endtask

    initial begin
        int px2, py2;
        px2 = -1;
        py2 = 0;
        m_phase = 0;
        for (int yy = 0; yy < 32; yy++) begin
            for (int xx = 0; xx < 10; xx++) begin
                if (px2 < 0 && m_cid(xx, yy, 0) == 2) begin
                    px2 = xx;
                    py2 = yy;
                end
            end
        end

        sys_rst            = 1'b1;
        pix_valid_in       = 1'b0;
        obstacle_x_rom     = '0;
        obstacle_y_rom     = '0;
        obstacle_abs_pos_x = '0;
        obstacle_abs_pos_y = '0;
        obstacle_on        = 1'b0;
        frame_start        = 1'b0;
        pal_we             = 1'b0;
        pal_addr           = '0;
        pal_data           = '0;

        cur_tag = "reset";
        sys_rst = 1'b1; tick();
        sys_rst = 1'b1; tick();

        cur_tag = "basic";
        req(3, 4, 0, 1); tick();
        repeat (3) tick();

        cur_tag = "mirror";
        req(0, 4, 1, 1); tick();
        repeat (3) tick();

        cur_tag = "anim";
        for (int i = 0; i < 29; i++) begin
            frame_start = 1'b1;
            if ($urandom_range(1, 0) == 1)
                req($urandom_range(1023, 0), $urandom_range(1023, 0), $urandom_range(16383, 0), 1);
            tick();
        end
        frame_start = 1'b1;
        req(5, 6, 1, 1); tick();
        req(5, 6, 1, 1); tick();
        req(5, 6, 0, 1); tick();
        req(5, 6, 3, 1); tick();
        repeat (3) tick();

        cur_tag = "palwr";
        req(px2, py2, 0, 1); tick();
        req(px2, py2, 0, 1); tick();
        pal_we = 1'b1; pal_addr = 2'd2; pal_data = 12'hF00; tick();
        repeat (3) tick();

        cur_tag = "alt";
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0)
                req($urandom_range(1023, 0), $urandom_range(1023, 0), $urandom_range(16383, 0),
                    (i / 2) % 2);
            tick();
        end
        repeat (3) tick();

        cur_tag = "rand";
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3, 0) != 0)
                req($urandom_range(1023, 0), $urandom_range(1023, 0), $urandom_range(16383, 0),
                    $urandom_range(1, 0));
            if ($urandom_range(7, 0) == 0) begin
                pal_we   = 1'b1;
                pal_addr = 2'($urandom);
                pal_data = 12'($urandom);
            end
            tick();
        end
        pal_we = 1'b1; pal_addr = 2'd2; pal_data = 12'h0F0; tick();

        cur_tag = "midrst";
        req(5, 6, 1, 1); tick();
        req(px2, py2, 0, 1); tick();
        req(1, 2, 3, 1); tick();
        sys_rst = 1'b1; req(7, 7, 7, 1); tick();
        tick();
        req(px2, py2, 0, 1); tick();
        req(5, 6, 1, 1); tick();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
